// File: rtl/pong_pkg.sv
// rtl/pong_pkg.sv - shared state encoding, default constants and player ids for the pong match sequencer
package pong_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SERVE = 3'd1,
    ST_PLAY  = 3'd2,
    ST_POINT = 3'd3,
    ST_OVER  = 3'd4
  } pong_state_t;

  localparam int DEF_WIN_SCORE      = 9;
  localparam int DEF_SCORE_W        = 4;
  localparam int DEF_SERVE_FRAMES   = 60;
  localparam int DEF_POINT_FRAMES   = 90;
  localparam int DEF_SPEED_INIT     = 2;
  localparam int DEF_SPEED_MAX      = 8;
  localparam int DEF_HITS_PER_LEVEL = 4;

  localparam logic PLAYER1 = 1'b0;
  localparam logic PLAYER2 = 1'b1;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/pong_match_ctrl_if.sv
// rtl/pong_match_ctrl_if.sv - button/datapath inputs and display/ball outputs of the match sequencer
interface pong_match_ctrl_if #(
  parameter int SCORE_W = 4
);
  logic               start;
  logic               frame_tick;
  logic               miss_left;
  logic               miss_right;
  logic               hit;
  logic               ball_run;
  logic               ball_respawn;
  logic               serve_dir;
  logic [3:0]         ball_speed;
  logic [SCORE_W-1:0] score1;
  logic [SCORE_W-1:0] score2;
  logic               game_over;
  logic               winner;

  modport master (
    output start, frame_tick, miss_left, miss_right, hit,
    input  ball_run, ball_respawn, serve_dir, ball_speed,
    input  score1, score2, game_over, winner
  );

  modport slave (
    input  start, frame_tick, miss_left, miss_right, hit,
    output ball_run, ball_respawn, serve_dir, ball_speed,
    output score1, score2, game_over, winner
  );
endinterface

// File: rtl/pong_frame_timer.sv
// rtl/pong_frame_timer.sv - counts frame ticks after a clear; done once the target count is reached
module pong_frame_timer #(
  parameter int CNT_W = 8
) (
  input  logic             i_mclk,
  input  logic             i_rst,
  input  logic             i_clear,
  input  logic             i_frame_tick,
  input  logic [CNT_W-1:0] i_target,
  output logic             o_done
);

  logic [CNT_W-1:0] r_count;
  logic             w_done;

  assign w_done = (r_count == i_target);
  assign o_done = w_done;

  // Counter saturates at the target so a long stall never wraps back below it.
  always_ff @(posedge i_mclk or posedge i_rst) begin
    if (i_rst) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_frame_tick && !w_done) begin
      r_count <= r_count + 1'b1;
    end
  end

endmodule

// File: rtl/pong_match_ctrl.sv
// rtl/pong_match_ctrl.sv - pong match FSM: scores, serve direction, speed level, ball gating
// PONG_SPEEDUP_EN builds the hit-driven speed ramp; otherwise speed stays at SPEED_INIT.
module pong_match_ctrl
  import pong_pkg::*;
#(
  parameter int WIN_SCORE      = DEF_WIN_SCORE,
  parameter int SCORE_W        = DEF_SCORE_W,
  parameter int SERVE_FRAMES   = DEF_SERVE_FRAMES,
  parameter int POINT_FRAMES   = DEF_POINT_FRAMES,
  parameter int SPEED_INIT     = DEF_SPEED_INIT,
  parameter int SPEED_MAX      = DEF_SPEED_MAX,
  parameter int HITS_PER_LEVEL = DEF_HITS_PER_LEVEL
) (
  input  logic            mclk,
  input  logic            rst,
  pong_match_ctrl_if.slave bus
);

  localparam int TMR_W = $clog2(max_int(SERVE_FRAMES, POINT_FRAMES) + 1);

  pong_state_t        r_state;
  logic               r_start_q;
  logic               r_entry;
  logic               r_ball_run;
  logic               r_ball_respawn;
  logic               r_serve_dir;
  logic [3:0]         r_speed;
  logic [SCORE_W-1:0] r_score1;
  logic [SCORE_W-1:0] r_score2;
  logic               r_game_over;
  logic               r_winner;
`ifdef PONG_SPEEDUP_EN
  localparam int HIT_W = $clog2(HITS_PER_LEVEL + 1);
  logic [HIT_W-1:0]   r_hits;
`endif

  logic               w_start_edge;
  logic [TMR_W-1:0]   w_target;
  logic               w_timer_done;
  logic               w_done;

  assign w_start_edge = bus.start && !r_start_q;
  assign w_target     = (r_state == ST_POINT) ? TMR_W'(POINT_FRAMES) : TMR_W'(SERVE_FRAMES);
  // The timer still holds the previous wait's count during the entry cycle.
  assign w_done       = w_timer_done && !r_entry;

  pong_frame_timer #(.CNT_W(TMR_W)) u_timer (
    .i_mclk       (mclk),
    .i_rst        (rst),
    .i_clear      (r_entry),
    .i_frame_tick (bus.frame_tick),
    .i_target     (w_target),
    .o_done       (w_timer_done)
  );

  always_ff @(posedge mclk or posedge rst) begin
    if (rst) begin
      r_state        <= ST_IDLE;
      r_start_q      <= 1'b0;
      r_entry        <= 1'b0;
      r_ball_run     <= 1'b0;
      r_ball_respawn <= 1'b0;
      r_serve_dir    <= 1'b0;
      r_speed        <= 4'(SPEED_INIT);
      r_score1       <= '0;
      r_score2       <= '0;
      r_game_over    <= 1'b0;
      r_winner       <= PLAYER1;
`ifdef PONG_SPEEDUP_EN
      r_hits         <= '0;
`endif
    end else begin
      r_start_q      <= bus.start;
      r_entry        <= 1'b0;
      r_ball_respawn <= 1'b0;
      case (r_state)
        ST_IDLE, ST_OVER: begin
          if (w_start_edge) begin
            r_score1       <= '0;
            r_score2       <= '0;
            r_game_over    <= 1'b0;
            r_winner       <= PLAYER1;
            if (r_state == ST_OVER) r_serve_dir <= 1'b0;
            r_state        <= ST_SERVE;
            r_entry        <= 1'b1;
            r_ball_respawn <= 1'b1;
            r_speed        <= 4'(SPEED_INIT);
`ifdef PONG_SPEEDUP_EN
            r_hits         <= '0;
`endif
          end
        end
        ST_SERVE: begin
          if (w_done) begin
            r_state    <= ST_PLAY;
            r_entry    <= 1'b1;
            r_ball_run <= 1'b1;
          end
        end
        ST_PLAY: begin
          if (bus.miss_left || bus.miss_right) begin
            r_state    <= ST_POINT;
            r_entry    <= 1'b1;
            r_ball_run <= 1'b0;
            // A simultaneous double miss is a replay: nobody scores.
            if (bus.miss_left && !bus.miss_right) begin
              if (r_score2 != SCORE_W'(WIN_SCORE)) r_score2 <= r_score2 + 1'b1;
              r_serve_dir <= 1'b0;
            end else if (bus.miss_right && !bus.miss_left) begin
              if (r_score1 != SCORE_W'(WIN_SCORE)) r_score1 <= r_score1 + 1'b1;
              r_serve_dir <= 1'b1;
            end
          end
`ifdef PONG_SPEEDUP_EN
          else if (bus.hit) begin
            if (r_hits == HIT_W'(HITS_PER_LEVEL - 1)) begin
              r_hits <= '0;
              if (r_speed != 4'(SPEED_MAX)) r_speed <= r_speed + 1'b1;
            end else begin
              r_hits <= r_hits + 1'b1;
            end
          end
`endif
        end
        ST_POINT: begin
          if (w_done) begin
            r_entry <= 1'b1;
            if (r_score1 == SCORE_W'(WIN_SCORE) || r_score2 == SCORE_W'(WIN_SCORE)) begin
              r_state     <= ST_OVER;
              r_game_over <= 1'b1;
              r_winner    <= (r_score2 == SCORE_W'(WIN_SCORE)) ? PLAYER2 : PLAYER1;
            end else begin
              r_state        <= ST_SERVE;
              r_ball_respawn <= 1'b1;
              r_speed        <= 4'(SPEED_INIT);
`ifdef PONG_SPEEDUP_EN
              r_hits         <= '0;
`endif
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.ball_run     = r_ball_run;
  assign bus.ball_respawn = r_ball_respawn;
  assign bus.serve_dir    = r_serve_dir;
  assign bus.ball_speed   = r_speed;
  assign bus.score1       = r_score1;
  assign bus.score2       = r_score2;
  assign bus.game_over    = r_game_over;
  assign bus.winner       = r_winner;

endmodule

// File: doc/pong_match_ctrl.md
Name: pong_match_ctrl

Overview:
- Match sequencer for the two-player bouncing-ball game; sits between the player buttons and the VGA display/ball datapath.
- Owns the game FSM (idle, serve, play, point pause, game over), per-player scores, serve direction and ball speed level.
- Gates ball motion and requests ball respawn from the display datapath.
- Exports scores and the winner to the seven-segment driver.

Parameters:
- WIN_SCORE, 9, points needed to win; must be < 2**SCORE_W.
- SCORE_W, 4, score counter width.
- SERVE_FRAMES, 60, frame ticks ball stays parked before launch.
- POINT_FRAMES, 90, frame ticks of pause after a point.
- SPEED_INIT, 2, ball speed level at each serve.
- SPEED_MAX, 8, speed level ceiling; must be < 16.
- HITS_PER_LEVEL, 4, paddle hits per speed increment.

Ports:
- mclk  in  1  system clock.
- rst  in  1  asynchronous reset, active-high.
- start  in  1  debounced start button (level).
- frame_tick  in  1  one-mclk pulse per video frame.
- miss_left  in  1  pulse: ball passed left paddle; point to player 2.
- miss_right  in  1  pulse: ball passed right paddle; point to player 1.
- hit  in  1  pulse: ball struck either paddle.
- ball_run  out  1  ball motion enable.
- ball_respawn  out  1  one-cycle pulse: recentre ball.
- serve_dir  out  1  0 = serve toward left, 1 = toward right.
- ball_speed  out  4  current speed level.
- score1  out  SCORE_W  player 1 score.
- score2  out  SCORE_W  player 2 score.
- game_over  out  1  high in OVER state.
- winner  out  1  0 = player 1, 1 = player 2; valid while game_over.

Behaviour:
- Reset values: state IDLE, ball_run 0, ball_respawn 0, serve_dir 0, ball_speed SPEED_INIT, scores 0, game_over 0, winner 0.
- All outputs are registered.
- start is registered internally; the rising edge (start_q low, start high) is the trigger. A held level never retriggers.

IDLE:
- Start edge: scores cleared, go to SERVE.

SERVE:
- On the entry cycle: ball_respawn pulses exactly one cycle and ball_speed loads SPEED_INIT.
- Frame counter is cleared on entry and counts frame_tick.
- After SERVE_FRAMES ticks, go to PLAY on the following cycle.
- ball_run stays 0.

PLAY:
- ball_run is 1.
- miss_left alone: score2 increments the next cycle, serve_dir <= 0 (loser serves toward self), go to POINT.
- miss_right alone: score1 increments the next cycle, serve_dir <= 1, go to POINT.
- miss_left and miss_right in the same cycle: no score change, serve_dir unchanged, go to POINT (replay).
- hit: hit counter increments. When it reaches HITS_PER_LEVEL it clears and ball_speed increments, saturating at SPEED_MAX.
- hit in the same cycle as a miss: the hit is ignored.

POINT:
- ball_run is 0; frame counter waits POINT_FRAMES ticks.
- Then: if score1 or score2 equals WIN_SCORE, go to OVER; else go to SERVE.

OVER:
- game_over is 1; winner = 1 if score2 == WIN_SCORE.
- Scores hold.
- Start edge: scores cleared, serve_dir <= 0, go to SERVE.

Boundary rules:
- miss and hit inputs are ignored outside PLAY.
- frame_tick and start are ignored in states that do not use them.
- A frame_tick coincident with state entry is not counted.
- Scores never exceed WIN_SCORE.
- A start edge during SERVE, PLAY or POINT is ignored.
- Reset mid-operation returns all outputs to reset values immediately.

Optional Feature:
- Macro: PONG_SPEEDUP_EN.
- Defined: hit-driven speed ramp as described under PLAY.
- Undefined: the hit counter is not built, hit is ignored, and ball_speed is constant SPEED_INIT.

Decomposition:
- Shared package pong_pkg holds:
  - state encoding (IDLE=0, SERVE=1, PLAY=2, POINT=3, OVER=4; 3 bits);
  - default WIN_SCORE, SERVE_FRAMES, POINT_FRAMES and speed constants;
  - player index constants.
- One sub-module, pong_frame_timer:
  - inputs: clear, frame_tick, target count; output: done;
  - reused for both the SERVE and POINT waits.

Test Plan:
(Bench parameters: WIN_SCORE=3, SERVE_FRAMES=2, POINT_FRAMES=2, HITS_PER_LEVEL=2, SPEED_INIT=2, SPEED_MAX=3.)
- Reset, then start edge: ball_respawn high exactly 1 cycle; ball_run rises the cycle after the 2nd frame_tick.
- In PLAY, pulse miss_right: score1 = 1 next cycle, serve_dir = 1, ball_run 0. After 2 ticks, back in SERVE with a respawn pulse.
- Drive miss_left and miss_right in the same cycle: scores unchanged, POINT entered, serve_dir unchanged.
- 6 hit pulses in PLAY: ball_speed goes 2 -> 3 after hit 2, then stays 3 (saturated). Speed returns to 2 on the next SERVE.
- Player 2 wins 3 points: game_over = 1, winner = 1, score2 = 3. Holding start high does nothing; a new edge clears scores and enters SERVE.
- Assert rst during PLAY with score1 = 2: all outputs return to reset values asynchronously, and the FSM is in IDLE.
